// File: rtl/locker_pkg.sv
// rtl/locker_pkg.sv - shared state enum, widths and default parameters for the locker bank
package locker_pkg;

    localparam int DEF_NUM_LOCKERS = 4;
    localparam int DEF_PRICE       = 3;
    localparam int DEF_TIMEOUT     = 255;

    localparam int ID_W     = 2;
    localparam int CREDIT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_GRANT   = 2'd2,
        ST_REFUND  = 2'd3
    } state_t;

endpackage

// File: rtl/locker_bank_ctrl_if.sv
// rtl/locker_bank_ctrl_if.sv - customer/key-return strobes and status outputs of the locker bank
interface locker_bank_ctrl_if
    import locker_pkg::*;
#(
    parameter int NUM_LOCKERS = DEF_NUM_LOCKERS
);
    logic                   coin;
    logic                   sel_valid;
    logic [ID_W-1:0]        sel_id;
    logic                   cancel;
    logic                   push;
    logic [ID_W-1:0]        ret_id;
    logic [NUM_LOCKERS-1:0] occupied;
    logic                   grant;
    logic [ID_W-1:0]        grant_id;
    logic                   refund;
    logic                   coin_reject;
    logic                   sel_err;
    logic [CREDIT_W-1:0]    credit;
    logic                   busy;

    modport master (
        output coin, sel_valid, sel_id, cancel, push, ret_id,
        input  occupied, grant, grant_id, refund, coin_reject, sel_err, credit, busy
    );

    modport slave (
        input  coin, sel_valid, sel_id, cancel, push, ret_id,
        output occupied, grant, grant_id, refund, coin_reject, sel_err, credit, busy
    );
endinterface

// File: rtl/locker_timer.sv
// rtl/locker_timer.sv - idle-cycle counter that flags when the customer has waited TIMEOUT cycles
module locker_timer
    import locker_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [W-1:0] r_count;

    // Count holds at TIMEOUT so it can never wrap back to a small value.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (enable && !expired) begin
            r_count <= r_count + W'(1);
        end
    end

    assign expired = (r_count == W'(TIMEOUT));

endmodule

// File: rtl/locker_bank_ctrl.sv
// rtl/locker_bank_ctrl.sv - coin-operated locker bank: selection, payment, grant, refund and key return
module locker_bank_ctrl
    import locker_pkg::*;
#(
    parameter int NUM_LOCKERS = DEF_NUM_LOCKERS,
    parameter int PRICE       = DEF_PRICE,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input logic               clk,
    input logic               rst,
    locker_bank_ctrl_if.slave bus
);
    state_t                 r_state;
    logic [ID_W-1:0]        r_id;
    logic [CREDIT_W-1:0]    r_credit;
    logic [NUM_LOCKERS-1:0] r_occupied;
    logic                   r_grant;
    logic [ID_W-1:0]        r_grant_id;
    logic                   r_refund;
    logic                   r_coin_reject;
    logic                   r_sel_err;

    logic [NUM_LOCKERS-1:0] w_occ_next;
    logic                   w_sel_taken;
    logic [CREDIT_W-1:0]    w_credit_inc;
    logic                   w_timer_clear;
    logic                   w_timer_enable;
    logic                   w_expired;

    assign w_credit_inc   = r_credit + CREDIT_W'(1);
    assign w_timer_clear  = (r_state != ST_COLLECT) || bus.coin;
    assign w_timer_enable = (r_state == ST_COLLECT) && !bus.coin;

    locker_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_timer_clear),
        .enable  (w_timer_enable),
        .expired (w_expired)
    );

    // Indices with no matching locker fall through as taken.
    always_comb begin
        w_sel_taken = 1'b1;
        for (int i = 0; i < NUM_LOCKERS; i++) begin
            if (bus.sel_id == ID_W'(i)) begin
                w_sel_taken = r_occupied[i];
            end
        end
    end

    // Release is applied before the grant so a same-index grant wins.
    always_comb begin
        w_occ_next = r_occupied;
        for (int i = 0; i < NUM_LOCKERS; i++) begin
            if (bus.push && bus.ret_id == ID_W'(i)) begin
                w_occ_next[i] = 1'b0;
            end
        end
        if (r_state == ST_GRANT) begin
            for (int i = 0; i < NUM_LOCKERS; i++) begin
                if (r_id == ID_W'(i)) begin
                    w_occ_next[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_id          <= '0;
            r_credit      <= '0;
            r_occupied    <= '0;
            r_grant       <= 1'b0;
            r_grant_id    <= '0;
            r_refund      <= 1'b0;
            r_coin_reject <= 1'b0;
            r_sel_err     <= 1'b0;
        end else begin
            r_grant       <= 1'b0;
            r_refund      <= 1'b0;
            r_coin_reject <= 1'b0;
            r_sel_err     <= 1'b0;
            r_occupied    <= w_occ_next;

            case (r_state)
                ST_IDLE: begin
                    r_coin_reject <= bus.coin;
                    if (bus.sel_valid) begin
                        if (w_sel_taken) begin
                            r_sel_err <= 1'b1;
                        end else begin
                            r_id     <= bus.sel_id;
                            r_credit <= '0;
                            r_state  <= ST_COLLECT;
                        end
                    end
                end

                // A coin is credited before cancel is considered; completing the price overrides cancel.
                ST_COLLECT: begin
                    if (bus.coin) begin
                        r_credit <= w_credit_inc;
                        if (w_credit_inc == CREDIT_W'(PRICE)) begin
                            r_state <= ST_GRANT;
                        end else if (bus.cancel) begin
                            r_state <= ST_REFUND;
                        end
                    end else if (bus.cancel || w_expired) begin
                        r_state <= ST_REFUND;
                    end
                end

                ST_GRANT: begin
                    r_coin_reject <= bus.coin;
                    r_grant       <= 1'b1;
                    r_grant_id    <= r_id;
                    r_credit      <= '0;
                    r_state       <= ST_IDLE;
                end

                ST_REFUND: begin
                    r_coin_reject <= bus.coin;
                    if (r_credit == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_refund <= 1'b1;
                        r_credit <= r_credit - CREDIT_W'(1);
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.occupied    = r_occupied;
    assign bus.grant       = r_grant;
    assign bus.grant_id    = r_grant_id;
    assign bus.refund      = r_refund;
    assign bus.coin_reject = r_coin_reject;
    assign bus.sel_err     = r_sel_err;
    assign bus.credit      = r_credit;
    assign bus.busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_locker_bank_ctrl.sv
// tb/tb_locker_bank_ctrl.sv - directed scenarios plus randomized traffic against a behavioural locker model
module tb_locker_bank_ctrl;
    localparam int N       = 4;
    localparam int PRICE   = 3;
    localparam int TIMEOUT = 255;

    localparam int PH_FREE  = 0;
    localparam int PH_PAY   = 1;
    localparam int PH_GIVE  = 2;
    localparam int PH_DRAIN = 3;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    locker_bank_ctrl_if #(.NUM_LOCKERS(N)) bus ();

    locker_bank_ctrl #(
        .NUM_LOCKERS (N),
        .PRICE       (PRICE),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state: a customer session described by phase, coins held and idle time.
    logic [N-1:0] m_occ;
    int           m_credit;
    int           m_phase;
    int           m_idle;
    logic [1:0]   m_sel;
    bit           e_grant, e_refund, e_reject, e_sel_err;
    logic [1:0]   e_grant_id;

    task automatic model_step(input bit r, input bit c, input bit sv, input logic [1:0] sid,
                              input bit can, input bit p, input logic [1:0] rid);
        logic [N-1:0] nocc;
        e_grant = 0; e_refund = 0; e_reject = 0; e_sel_err = 0;
        if (r) begin
            m_occ = '0; m_credit = 0; m_phase = PH_FREE; m_idle = 0;
            return;
        end
        nocc = m_occ;
        if (p) nocc[rid] = 1'b0;
        case (m_phase)
            PH_FREE: begin
                e_reject = c;
                if (sv) begin
                    if (m_occ[sid]) e_sel_err = 1;
                    else begin m_sel = sid; m_credit = 0; m_idle = 0; m_phase = PH_PAY; end
                end
            end
            PH_PAY: begin
                if (c) begin
                    m_credit++; m_idle = 0;
                    if (m_credit == PRICE) m_phase = PH_GIVE;
                    else if (can) m_phase = PH_DRAIN;
                end else if (can || m_idle >= TIMEOUT) m_phase = PH_DRAIN;
                else m_idle++;
            end
            PH_GIVE: begin
                e_reject = c; e_grant = 1; e_grant_id = m_sel;
                nocc[m_sel] = 1'b1; m_credit = 0; m_phase = PH_FREE;
            end
            default: begin
                e_reject = c;
                if (m_credit == 0) m_phase = PH_FREE;
                else begin e_refund = 1; m_credit--; end
            end
        endcase
        m_occ = nocc;
    endtask

    task automatic cycle(input bit r, input bit c, input bit sv, input logic [1:0] sid,
                         input bit can, input bit p, input logic [1:0] rid);
        rst = r; bus.coin = c; bus.sel_valid = sv; bus.sel_id = sid;
        bus.cancel = can; bus.push = p; bus.ret_id = rid;
        model_step(r, c, sv, sid, can, p, rid);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        cycle(0, 0, 0, 2'd0, 0, 0, 2'd0);
    endtask

    task automatic rent(input logic [1:0] id);
        cycle(0, 0, 1, id, 0, 0, 2'd0);
        for (int i = 0; i < PRICE; i++) cycle(0, 1, 0, 2'd0, 0, 0, 2'd0);
        idle_cycle();
    endtask

    task automatic test_reset();
        cycle(1, 1, 1, 2'd2, 1, 1, 2'd1);
        cycle(1, 1, 0, 2'd0, 0, 0, 2'd0);
        checks++; if (bus.occupied !== 4'b0000) begin failures++; $display("FAIL reset_occupied got=%b exp=0000", bus.occupied); end
        checks++; if (bus.credit !== 3'd0) begin failures++; $display("FAIL reset_credit got=%0d exp=0", bus.credit); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if ({bus.grant, bus.refund, bus.coin_reject, bus.sel_err} !== 4'b0000) begin
            failures++; $display("FAIL reset_pulses got=%b exp=0000", {bus.grant, bus.refund, bus.coin_reject, bus.sel_err});
        end
        cycle(0, 0, 0, 2'd0, 0, 0, 2'd0);
    endtask

    task automatic test_rent();
        cycle(0, 0, 1, 2'd2, 0, 0, 2'd0);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL rent_busy got=%b exp=1", bus.busy); end
        for (int k = 1; k <= PRICE; k++) begin
            cycle(0, 1, 0, 2'd0, 0, 0, 2'd0);
            checks++; if (bus.credit !== 3'(k)) begin failures++; $display("FAIL rent_credit got=%0d exp=%0d", bus.credit, k); end
        end
        idle_cycle();
        checks++; if (bus.grant !== 1'b1 || bus.grant_id !== 2'd2) begin
            failures++; $display("FAIL rent_grant got=%b/%0d exp=1/2", bus.grant, bus.grant_id);
        end
        checks++; if (bus.occupied !== 4'b0100) begin failures++; $display("FAIL rent_occupied got=%b exp=0100", bus.occupied); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rent_busy_after got=%b exp=0", bus.busy); end
        idle_cycle();
        checks++; if (bus.grant !== 1'b0) begin failures++; $display("FAIL rent_grant_pulse got=%b exp=0", bus.grant); end
    endtask

    task automatic test_sel_err();
        rent(2'd1);
        checks++; if (bus.occupied !== 4'b0110) begin failures++; $display("FAIL selerr_occ got=%b exp=0110", bus.occupied); end
        cycle(0, 0, 1, 2'd1, 0, 0, 2'd0);
        checks++; if (bus.sel_err !== 1'b1 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL selerr_pulse got=%b busy=%b exp=1 busy=0", bus.sel_err, bus.busy);
        end
        idle_cycle();
        checks++; if (bus.sel_err !== 1'b0) begin failures++; $display("FAIL selerr_once got=%b exp=0", bus.sel_err); end
    endtask

    task automatic test_cancel();
        cycle(0, 0, 1, 2'd0, 0, 0, 2'd0);
        cycle(0, 1, 0, 2'd0, 0, 0, 2'd0);
        cycle(0, 1, 0, 2'd0, 0, 0, 2'd0);
        cycle(0, 0, 0, 2'd0, 1, 0, 2'd0);
        checks++; if (bus.refund !== 1'b0 || bus.credit !== 3'd2) begin
            failures++; $display("FAIL cancel_entry got=%b/%0d exp=0/2", bus.refund, bus.credit);
        end
        for (int k = 1; k >= 0; k--) begin
            idle_cycle();
            checks++; if (bus.refund !== 1'b1 || bus.credit !== 3'(k)) begin
                failures++; $display("FAIL cancel_refund got=%b/%0d exp=1/%0d", bus.refund, bus.credit, k);
            end
        end
        idle_cycle();
        checks++; if (bus.refund !== 1'b0 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL cancel_done got=%b busy=%b exp=0 busy=0", bus.refund, bus.busy);
        end
    endtask

    task automatic test_timeout();
        int refunds;
        bit dropped;
        refunds = 0; dropped = 0;
        cycle(0, 0, 1, 2'd3, 0, 0, 2'd0);
        cycle(0, 1, 0, 2'd0, 0, 0, 2'd0);
        for (int i = 0; i < TIMEOUT; i++) begin
            idle_cycle();
            if (bus.refund) refunds++;
            if (!bus.busy) dropped = 1;
        end
        checks++; if (refunds != 0 || dropped) begin
            failures++; $display("FAIL timeout_early refunds=%0d dropped=%0d exp=0/0", refunds, dropped);
        end
        idle_cycle();
        checks++; if (bus.refund !== 1'b0 || bus.busy !== 1'b1) begin
            failures++; $display("FAIL timeout_entry got=%b busy=%b exp=0 busy=1", bus.refund, bus.busy);
        end
        idle_cycle();
        checks++; if (bus.refund !== 1'b1 || bus.credit !== 3'd0) begin
            failures++; $display("FAIL timeout_refund got=%b/%0d exp=1/0", bus.refund, bus.credit);
        end
        idle_cycle();
        checks++; if (bus.refund !== 1'b0 || bus.busy !== 1'b0 || bus.occupied !== 4'b0110) begin
            failures++; $display("FAIL timeout_done got=%b busy=%b occ=%b exp=0 0 0110", bus.refund, bus.busy, bus.occupied);
        end
    endtask

    task automatic test_grant_release();
        cycle(0, 0, 1, 2'd0, 0, 0, 2'd0);
        for (int i = 0; i < PRICE; i++) cycle(0, 1, 0, 2'd0, 0, 0, 2'd0);
        cycle(0, 1, 0, 2'd0, 0, 1, 2'd1);
        checks++; if (bus.occupied !== 4'b0101 || bus.grant !== 1'b1 || bus.grant_id !== 2'd0) begin
            failures++; $display("FAIL grantrel_occ got=%b g=%b id=%0d exp=0101 1 0", bus.occupied, bus.grant, bus.grant_id);
        end
        checks++; if (bus.coin_reject !== 1'b1 || bus.credit !== 3'd0) begin
            failures++; $display("FAIL grantrel_reject got=%b cr=%0d exp=1 0", bus.coin_reject, bus.credit);
        end
        cycle(0, 0, 0, 2'd0, 0, 1, 2'd0);
        checks++; if (bus.occupied !== 4'b0100) begin failures++; $display("FAIL release_occ got=%b exp=0100", bus.occupied); end
        cycle(0, 0, 1, 2'd0, 0, 0, 2'd0);
        for (int i = 0; i < PRICE; i++) cycle(0, 1, 0, 2'd0, 0, 0, 2'd0);
        cycle(0, 0, 0, 2'd0, 0, 1, 2'd0);
        checks++; if (bus.occupied !== 4'b0101) begin failures++; $display("FAIL same_idx_grant got=%b exp=0101", bus.occupied); end
    endtask

    task automatic test_reset_mid();
        int refunds;
        refunds = 0;
        cycle(0, 0, 1, 2'd1, 0, 0, 2'd0);
        cycle(0, 1, 0, 2'd0, 0, 0, 2'd0);
        cycle(0, 1, 0, 2'd0, 0, 0, 2'd0);
        checks++; if (bus.credit !== 3'd2) begin failures++; $display("FAIL rstmid_pre got=%0d exp=2", bus.credit); end
        cycle(1, 0, 0, 2'd0, 0, 0, 2'd0);
        checks++; if (bus.credit !== 3'd0 || bus.busy !== 1'b0 || bus.occupied !== 4'b0000) begin
            failures++; $display("FAIL rstmid_state cr=%0d busy=%b occ=%b exp=0 0 0000", bus.credit, bus.busy, bus.occupied);
        end
        for (int i = 0; i < 4; i++) begin
            idle_cycle();
            if (bus.refund) refunds++;
        end
        checks++; if (refunds != 0) begin failures++; $display("FAIL rstmid_refund got=%0d exp=0", refunds); end
    endtask

    task automatic test_random();
        int fails_here;
        bit r, c, sv, can, p;
        logic [1:0] sid, rid;
        fails_here = 0;
        for (int n = 0; n < 4000 && fails_here < 10; n++) begin
            r   = ($urandom_range(0, 199) == 0);
            c   = ($urandom_range(0, 9) < 4);
            sv  = ($urandom_range(0, 9) < 2);
            can = ($urandom_range(0, 29) == 0);
            p   = ($urandom_range(0, 9) == 0);
            sid = 2'($urandom_range(0, 3));
            rid = 2'($urandom_range(0, 3));
            cycle(r, c, sv, sid, can, p, rid);
            checks++; if (bus.occupied !== m_occ) begin failures++; fails_here++; $display("FAIL rnd_occ n=%0d got=%b exp=%b", n, bus.occupied, m_occ); end
            checks++; if (bus.credit !== 3'(m_credit)) begin failures++; fails_here++; $display("FAIL rnd_credit n=%0d got=%0d exp=%0d", n, bus.credit, m_credit); end
            checks++; if (bus.busy !== (m_phase != PH_FREE)) begin failures++; fails_here++; $display("FAIL rnd_busy n=%0d got=%b exp=%b", n, bus.busy, m_phase != PH_FREE); end
            checks++; if (bus.grant !== e_grant) begin failures++; fails_here++; $display("FAIL rnd_grant n=%0d got=%b exp=%b", n, bus.grant, e_grant); end
            if (e_grant) begin
                checks++; if (bus.grant_id !== e_grant_id) begin failures++; fails_here++; $display("FAIL rnd_grant_id n=%0d got=%0d exp=%0d", n, bus.grant_id, e_grant_id); end
            end
            checks++; if (bus.refund !== e_refund) begin failures++; fails_here++; $display("FAIL rnd_refund n=%0d got=%b exp=%b", n, bus.refund, e_refund); end
            checks++; if (bus.coin_reject !== e_reject) begin failures++; fails_here++; $display("FAIL rnd_reject n=%0d got=%b exp=%b", n, bus.coin_reject, e_reject); end
            checks++; if (bus.sel_err !== e_sel_err) begin failures++; fails_here++; $display("FAIL rnd_sel_err n=%0d got=%b exp=%b", n, bus.sel_err, e_sel_err); end
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        m_occ = '0; m_credit = 0; m_phase = PH_FREE; m_idle = 0; m_sel = 2'd0;
        e_grant_id = 2'd0;
        test_reset();
        test_rent();
        test_sel_err();
        test_cancel();
        test_timeout();
        test_grant_release();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
